// File: rtl/truth_table_bist_pkg.sv
// Shared definitions for the truth-table self-test sequencer: state encoding
// and the default parameters for the team's 3-input minterm block.
package truth_table_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         DEFAULT_N_IN     = 3;
    localparam int         DEFAULT_SETTLE   = 1;
    // Minterms 0, 4 and 5 of {a,b,c}, a as the MSB.
    localparam logic [7:0] DEFAULT_EXP_MASK = 8'h31;

endpackage

// File: rtl/truth_table_bist_if.sv
// Control/observation bundle between the BIST sequencer (slave) and the
// host plus the block under test (master).
interface truth_table_bist_if #(
    parameter int N_IN = 3
);

    logic                   start;
    logic [N_IN-1:0]        dut_in;
    logic                   dut_y;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(2**N_IN)-1:0]   captured;
    logic [N_IN-1:0]        fail_idx;

    modport slave (
        input  start,
        input  dut_y,
        output dut_in,
        output busy,
        output done,
        output pass,
        output captured,
        output fail_idx
    );

    modport master (
        output start,
        output dut_y,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  captured,
        input  fail_idx
    );

endinterface

// File: rtl/truth_table_bist_lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of vec, with
// a flag for the all-zero case.
module lowest_set_index #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          none
);

    logic found_s;

    // Scan upward and latch onto the first set bit found.
    always_comb begin
        idx     = {IW{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!found_s && vec[i]) begin
                idx     = IW'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        none = ~found_s;
    end

endmodule

// File: rtl/truth_table_bist.sv
// Walks every input combination of a small combinational block, records its
// response and compares the result against a compile-time truth table.
module truth_table_bist
    import truth_table_bist_pkg::*;
#(
    parameter int                   N_IN     = DEFAULT_N_IN,
    parameter logic [(2**N_IN)-1:0] EXP_MASK = (2**N_IN)'(DEFAULT_EXP_MASK),
    parameter int                   SETTLE   = DEFAULT_SETTLE
) (
    input logic                 clk,
    input logic                 rst_n,
    truth_table_bist_if.slave   bus
);

    localparam int              NV       = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

    state_t            state_r, state_nxt_s;
    logic [N_IN-1:0]   idx_r, idx_nxt_s;
    logic [3:0]        cnt_r, cnt_nxt_s;
    logic [N_IN-1:0]   dut_in_r, dut_in_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              pass_r, pass_nxt_s;
    logic [NV-1:0]     captured_r, captured_nxt_s;
    logic [N_IN-1:0]   fail_idx_r, fail_idx_nxt_s;
    logic [N_IN-1:0]   lsi_idx_s;
    logic              lsi_none_s;
    logic              sample_s;
    logic              last_s;

    assign sample_s = (cnt_r >= SETTLE_C);
    assign last_s   = (idx_r == LAST_IDX);

    lowest_set_index #(.W(NV), .IW(N_IN)) u_lsi (
        .vec  (captured_r ^ EXP_MASK),
        .idx  (lsi_idx_s),
        .none (lsi_none_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is only honoured when no run is in flight.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) state_nxt_s = RUN;
                else           state_nxt_s = state_r;
            end
            RUN: begin
                if (sample_s && last_s) state_nxt_s = CHECK;
                else                    state_nxt_s = RUN;
            end
            CHECK:   state_nxt_s = DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        idx_nxt_s      = idx_r;
        cnt_nxt_s      = cnt_r;
        dut_in_nxt_s   = dut_in_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = done_r;
        pass_nxt_s     = pass_r;
        captured_nxt_s = captured_r;
        fail_idx_nxt_s = fail_idx_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    idx_nxt_s      = {N_IN{1'b0}};
                    cnt_nxt_s      = 4'd0;
                    dut_in_nxt_s   = {N_IN{1'b0}};
                    busy_nxt_s     = 1'b1;
                    done_nxt_s     = 1'b0;
                    pass_nxt_s     = 1'b0;
                    captured_nxt_s = {NV{1'b0}};
                    fail_idx_nxt_s = {N_IN{1'b0}};
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            RUN: begin
                if (!sample_s) begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end else begin
                    // Final edge of this vector's window: record the response.
                    captured_nxt_s[idx_r] = bus.dut_y;
                    cnt_nxt_s             = 4'd0;
                    if (last_s) begin
                        idx_nxt_s = idx_r;
                    end else begin
                        idx_nxt_s    = idx_r + {{(N_IN-1){1'b0}}, 1'b1};
                        dut_in_nxt_s = idx_r + {{(N_IN-1){1'b0}}, 1'b1};
                    end
                end
            end
            CHECK: begin
                pass_nxt_s     = (captured_r == EXP_MASK);
                fail_idx_nxt_s = lsi_none_s ? {N_IN{1'b0}} : lsi_idx_s;
                busy_nxt_s     = 1'b0;
                done_nxt_s     = 1'b1;
            end
            default: begin
                idx_nxt_s = {N_IN{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r      <= {N_IN{1'b0}};
            cnt_r      <= 4'd0;
            dut_in_r   <= {N_IN{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            captured_r <= {NV{1'b0}};
            fail_idx_r <= {N_IN{1'b0}};
        end else begin
            idx_r      <= idx_nxt_s;
            cnt_r      <= cnt_nxt_s;
            dut_in_r   <= dut_in_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            pass_r     <= pass_nxt_s;
            captured_r <= captured_nxt_s;
            fail_idx_r <= fail_idx_nxt_s;
        end
    end

    assign bus.dut_in   = dut_in_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = pass_r;
    assign bus.captured = captured_r;
    assign bus.fail_idx = fail_idx_r;

endmodule

// File: tb/tb_truth_table_bist.sv
// Bench for truth_table_bist: three instances (SETTLE 1, 0, 3), each driving
// a table-defined block under test, checked against a behavioural model.
module tb_truth_table_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [7:0] EXP = 8'h31;

    logic [7:0] tbl     [3];
    logic       start_v [3];

    truth_table_bist_if #(.N_IN(3)) bus0 ();
    truth_table_bist_if #(.N_IN(3)) bus1 ();
    truth_table_bist_if #(.N_IN(3)) bus2 ();

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus0.dut_y = tbl[0][bus0.dut_in];
    assign bus1.dut_y = tbl[1][bus1.dut_in];
    assign bus2.dut_y = tbl[2][bus2.dut_in];

    truth_table_bist #(.SETTLE(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    truth_table_bist #(.SETTLE(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    truth_table_bist #(.SETTLE(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    logic [2:0] din_w  [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [7:0] cap_w  [3];
    logic [2:0] fidx_w [3];

    assign din_w[0] = bus0.dut_in;   assign din_w[1] = bus1.dut_in;   assign din_w[2] = bus2.dut_in;
    assign busy_w[0] = bus0.busy;    assign busy_w[1] = bus1.busy;    assign busy_w[2] = bus2.busy;
    assign done_w[0] = bus0.done;    assign done_w[1] = bus1.done;    assign done_w[2] = bus2.done;
    assign pass_w[0] = bus0.pass;    assign pass_w[1] = bus1.pass;    assign pass_w[2] = bus2.pass;
    assign cap_w[0] = bus0.captured; assign cap_w[1] = bus1.captured; assign cap_w[2] = bus2.captured;
    assign fidx_w[0] = bus0.fail_idx; assign fidx_w[1] = bus1.fail_idx; assign fidx_w[2] = bus2.fail_idx;

    // Correct block: y = ~a~b~c | a~b~c | a~bc, written as a boolean equation.
    function automatic logic [7:0] correct_table();
        logic [7:0] t;
        logic [2:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            t[k] = ~v[1] & (v[2] | ~v[0]);
        end
        return t;
    endfunction

    function automatic logic [2:0] model_fail_idx(input logic [7:0] got);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (got[k] != EXP[k]) r = 3'(k);
        end
        return r;
    endfunction

    task automatic do_run(input int inst, input int settle, input logic [7:0] t,
                          input int poke_c, input string tag);
        int         c;
        int         exp_v;
        bit         seq_ok;
        tbl[inst] = t;
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(posedge clk); #1;
        start_v[inst] = 1'b0;
        c = 0;
        seq_ok = 1'b1;
        while (done_w[inst] !== 1'b1 && c < 200) begin
            exp_v = c / (settle + 1);
            if (exp_v > 7) exp_v = 7;
            if (din_w[inst] !== 3'(exp_v) || busy_w[inst] !== 1'b1) seq_ok = 1'b0;
            if (c == poke_c) start_v[inst] = 1'b1;
            else             start_v[inst] = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        start_v[inst] = 1'b0;
        n_chk++;
        if (!seq_ok) $display("FAIL %s seq: dut_in/busy sequence wrong (settle %0d)", tag, settle);
        else n_pass++;
        n_chk++;
        if (c !== 8 * (settle + 1) + 1) $display("FAIL %s latency: got %0d need %0d", tag, c, 8 * (settle + 1) + 1);
        else n_pass++;
        n_chk++;
        if (cap_w[inst] !== t) $display("FAIL %s captured: got %h need %h", tag, cap_w[inst], t);
        else n_pass++;
        n_chk++;
        if (pass_w[inst] !== (t == EXP)) $display("FAIL %s pass: got %b need %b", tag, pass_w[inst], (t == EXP));
        else n_pass++;
        n_chk++;
        if (fidx_w[inst] !== model_fail_idx(t)) $display("FAIL %s fail_idx: got %0d need %0d", tag, fidx_w[inst], model_fail_idx(t));
        else n_pass++;
        n_chk++;
        if (busy_w[inst] !== 1'b0 || din_w[inst] !== 3'd7) $display("FAIL %s end: busy %b dut_in %0d need 0/7", tag, busy_w[inst], din_w[inst]);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({din_w[i], busy_w[i], done_w[i], pass_w[i], cap_w[i], fidx_w[i]} !== 17'd0)
                $display("FAIL reset inst%0d: outputs %h need 0", i,
                         {din_w[i], busy_w[i], done_w[i], pass_w[i], cap_w[i], fidx_w[i]});
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_patterns();
        do_run(0, 1, correct_table(), -1, "correct");
        do_run(0, 1, 8'hFF, -1, "stuck1");
        do_run(0, 1, 8'hB1, -1, "idx7");
        for (int r = 0; r < 4; r++) begin
            do_run(0, 1, 8'($urandom_range(0, 255)), -1, "random");
        end
    endtask

    task automatic test_reset_midrun();
        int c;
        tbl[0] = 8'hFF;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        c = 0;
        while (din_w[0] !== 3'd3 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        n_chk++;
        if (din_w[0] !== 3'd3) $display("FAIL midrun_reach: dut_in %0d need 3", din_w[0]);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({din_w[0], busy_w[0], done_w[0], pass_w[0], cap_w[0], fidx_w[0]} !== 17'd0)
            $display("FAIL midrun_reset: outputs %h need 0",
                     {din_w[0], busy_w[0], done_w[0], pass_w[0], cap_w[0], fidx_w[0]});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        do_run(0, 1, correct_table(), -1, "after_reset");
    endtask

    task automatic test_ignore_start();
        do_run(0, 1, correct_table(), 9, "ignore_start");
    endtask

    task automatic test_hold_start();
        int c;
        tbl[0] = correct_table();
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        c = 0;
        while (done_w[0] !== 1'b1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        n_chk++;
        if (done_w[0] !== 1'b1) $display("FAIL hold_first_done: done %b need 1", done_w[0]);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || cap_w[0] !== 8'h00)
            $display("FAIL hold_restart: done %b busy %b captured %h need 0/1/00", done_w[0], busy_w[0], cap_w[0]);
        else n_pass++;
        c = 0;
        while (done_w[0] !== 1'b1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        n_chk++;
        if (c !== 17) $display("FAIL hold_latency: got %0d need 17", c);
        else n_pass++;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (done_w[0] !== 1'b1 || pass_w[0] !== 1'b1) $display("FAIL hold_stop: done %b pass %b need 1/1", done_w[0], pass_w[0]);
        else n_pass++;
    endtask

    task automatic test_settle();
        do_run(1, 0, correct_table(), -1, "settle0");
        do_run(2, 3, correct_table(), -1, "settle3");
        do_run(1, 0, 8'h30, -1, "settle0_bad");
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            tbl[i]     = correct_table();
        end
        test_reset();
        test_patterns();
        test_reset_midrun();
        test_ignore_start();
        test_hold_start();
        test_settle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/truth_table_bist.md
Name: truth_table_bist

Overview:
Self-test sequencer that drives the inputs of a small combinational function block and checks its output.
- Walks all 2^N_IN input combinations in ascending order.
- Captures the block's output for each combination into a response vector.
- Compares the response vector against a compile-time expected truth table.
- Reports pass/fail and the lowest failing index.
- Sits beside the 3-input minterm logic blocks as their stimulus/check end; used in board bring-up and simulation.

Parameters:
- N_IN, 3, number of DUT inputs; the vector count is 2^N_IN.
- EXP_MASK, 8'h31, expected truth table. Bit k is the expected y for input value k. The default is minterms 0, 4 and 5, i.e. y = ~a~b~c | a~b~c | a~bc with a as the MSB.
- SETTLE, 1, extra cycles to hold each input vector before sampling (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset.
- start  in  1  request a test run; sampled only in IDLE or DONE.
- dut_in  out  N_IN  stimulus to DUT; {a,b,c} ordering with a as the MSB.
- dut_y  in  1  DUT output; same clock domain, combinational path, no synchroniser.
- busy  out  1  high from the start-accept edge until DONE is entered.
- done  out  1  level; high in DONE until the next accepted start or reset.
- pass  out  1  valid when done=1; 1 means captured==EXP_MASK.
- captured  out  2^N_IN  response vector; bit k = dut_y sampled while dut_in==k.
- fail_idx  out  N_IN  lowest k with captured[k]!=EXP_MASK[k]; 0 when pass=1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values, applied immediately on rst_n low:
  - state=IDLE, dut_in=0, busy=0, done=0, pass=0, captured=0, fail_idx=0.
  - Internal idx=0, cnt=0.
- States: IDLE, RUN, CHECK, DONE.
- IDLE or DONE, start=1 at edge E0:
  - state←RUN, idx←0, dut_in←0, cnt←0.
  - captured←0, done←0, pass←0, fail_idx←0, busy←1.
- RUN, each edge:
  - If cnt<SETTLE: cnt←cnt+1.
  - Else capture edge: captured[idx]←dut_y, cnt←0.
    - If idx==2^N_IN−1: state←CHECK, dut_in held.
    - Else idx←idx+1, dut_in←idx+1.
- Vector timing: each vector is driven for exactly SETTLE+1 cycles; dut_y is sampled on the final edge of that window.
- CHECK, one edge:
  - pass←(captured==EXP_MASK).
  - fail_idx←lowest set bit of captured^EXP_MASK, or 0 if none.
  - busy←0, done←1, state←DONE.
- Latency: done rises on edge E0 + 2^N_IN·(SETTLE+1) + 1. Default: E0+17.
- DONE: all outputs hold. dut_in stays at 2^N_IN−1.
- Boundary conditions:
  - start while in RUN or CHECK is ignored; no restart, no queuing.
  - start held high continuously: a new run starts on the first edge in DONE, so done is high for exactly one cycle per run.
  - rst_n low mid-run: immediate return to reset values; no partial result is retained.
  - SETTLE=0: one cycle per vector, sampling on every RUN edge.
  - idx does not wrap into a second pass; RUN exits after index 2^N_IN−1.
  - X or Z on dut_y is captured as-is; the bench treats it as an error.

Decomposition:
- Shared include/package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, CHECK=2'd2, DONE=2'd3.
  - Default EXP_MASK for the team's 3-input function.
- One sub-module, lowest_set_index (parameter W): combinational priority encoder over W bits; outputs the index and a none flag. It computes fail_idx.

Test Plan:
1. Correct DUT model (minterms 0,4,5), default parameters, pulse start → done on edge E0+17, pass=1, captured=8'h31, fail_idx=0, dut_in sequence 0..7 with each value held 2 cycles.
2. DUT stuck-at-1 → captured=8'hFF, pass=0, fail_idx=1.
3. DUT with only index 7 wrong (y=1 at 111) → captured=8'hB1, pass=0, fail_idx=7.
4. Drive rst_n low while idx=3, release, pulse start → all outputs read reset values during reset; the following run completes normally with pass=1.
5. Pulse start during RUN (idx=4) → no effect, done on original schedule. Start held high from DONE → new run begins; done high exactly one cycle; captured cleared on restart.
6. SETTLE=0 instance with correct DUT → done on edge E0+9, pass=1. SETTLE=3 instance → done on edge E0+33.
